// File: rtl/key_event_detector.sv
// Multi-channel key event detector: per channel a synchroniser, a debounce filter,
// an edge detector (rise/fall/both) and an optional typematic auto-repeat.
module key_event_detector #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_RATE     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] debounced,
    output logic                any_tick
);

    localparam int unsigned DBW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned RPMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPW   = $clog2(RPMAX) + 1;

    localparam logic [1:0] MODE_RISE   = 2'b00;
    localparam logic [1:0] MODE_FALL   = 2'b01;
    localparam logic [1:0] MODE_BOTH   = 2'b10;
    localparam logic [1:0] MODE_REPEAT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HELD   = 2'b01,
        ST_REPEAT = 2'b10
    } rep_state_t;

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sy;
        logic                   deb_q;
        logic                   deb_d;
        logic [DBW-1:0]         dcnt_q;
        logic [DBW-1:0]         dcnt_d;
        logic                   rise;
        logic                   fall;
        logic                   edge_tick;
        logic                   rep_tick;
        rep_state_t             state_q;
        rep_state_t             state_d;
        logic [RPW-1:0]         rcnt_q;
        logic [RPW-1:0]         rcnt_d;
        logic                   tick_q;
        logic                   tick_d;

        // Input synchroniser chain
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) sync_q <= '0;
            else      sync_q <= {sync_q[SYNC_STAGES-2:0], level[i]};
        end

        assign sy = sync_q[SYNC_STAGES-1];

        // Debounce: accept a change only after DEBOUNCE_CYCLES consecutive differing samples
        always_comb begin
            deb_d  = deb_q;
            dcnt_d = '0;
            if (sy != deb_q) begin
                if (dcnt_q == DBW'(DEBOUNCE_CYCLES - 1)) deb_d = sy;
                else                                     dcnt_d = dcnt_q + DBW'(1);
            end
        end

        assign rise = deb_d & ~deb_q;
        assign fall = ~deb_d & deb_q;

        // Edge selection, repeat FSM next state and the registered tick
        always_comb begin
            state_d   = state_q;
            rcnt_d    = rcnt_q;
            rep_tick  = 1'b0;
            edge_tick = 1'b0;
            tick_d    = 1'b0;

            case (mode)
                MODE_RISE, MODE_REPEAT: edge_tick = rise;
                MODE_FALL:              edge_tick = fall;
                MODE_BOTH:              edge_tick = rise | fall;
                default:                edge_tick = 1'b0;
            endcase

            if (!en || (mode != MODE_REPEAT) || fall) begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            state_d = ST_HELD;
                            rcnt_d  = '0;
                        end
                    end
                    ST_HELD: begin
                        if (rcnt_q == RPW'(REPEAT_DELAY - 1)) begin
                            rep_tick = 1'b1;
                            state_d  = ST_REPEAT;
                            rcnt_d   = '0;
                        end else begin
                            rcnt_d = rcnt_q + RPW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (rcnt_q == RPW'(REPEAT_RATE - 1)) begin
                            rep_tick = 1'b1;
                            rcnt_d   = '0;
                        end else begin
                            rcnt_d = rcnt_q + RPW'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end

            tick_d = en & (edge_tick | rep_tick);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                deb_q   <= 1'b0;
                dcnt_q  <= '0;
                state_q <= ST_IDLE;
                rcnt_q  <= '0;
                tick_q  <= 1'b0;
            end else begin
                deb_q   <= deb_d;
                dcnt_q  <= dcnt_d;
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
                tick_q  <= tick_d;
            end
        end

        assign tick[i]      = tick_q;
        assign debounced[i] = deb_q;
    end

    assign any_tick = |tick;

endmodule

// File: tb/tb_key_event_detector.sv
// Scoreboard bench for key_event_detector: stimulus queues expected ticks with their
// cycle numbers, a monitor pops them as tick pulses appear.
module tb_key_event_detector;

    localparam int unsigned LAT = 18;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] level;
    logic [3:0] tick;
    logic [3:0] debounced;
    logic       any_tick;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  vec;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc    = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    key_event_detector dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .level     (level),
        .tick      (tick),
        .debounced (debounced),
        .any_tick  (any_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic expect_tick(input int unsigned at, input logic [3:0] vec);
        exp_t e;
        e.cyc = at;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compares each tick pulse against the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("reset_tick", 32'(tick), 32'h0);
            check("reset_debounced", 32'(debounced), 32'h0);
        end else begin
            check("any_tick_or", 32'(any_tick), 32'(|tick));
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_tick: expected %0h at cycle %0d, still pending at cycle %0d",
                         e.vec, e.cyc, cyc);
            end
            if (tick != 4'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick: got %0h at cycle %0d, expected none", tick, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("tick_cycle", cyc, e.cyc);
                    check("tick_vector", 32'(tick), 32'(e.vec));
                end
            end
        end
    end

    initial begin
        int unsigned c;
        int unsigned fall_at;

        rst   = 1'b0;
        en    = 1'b1;
        mode  = 2'b00;
        level = 4'b0;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(5);

        // Rising mode: one tick 18 cycles after the press, debounced flips on that edge
        c = cyc;
        level[0] = 1'b1;
        expect_tick(c + LAT, 4'b0001);
        wait_cycles(LAT - 1);
        check("deb0_before", 32'(debounced[0]), 32'h0);
        wait_cycles(1);
        check("deb0_after", 32'(debounced[0]), 32'h1);
        wait_cycles(22);
        level[0] = 1'b0;
        wait_cycles(30);
        check("deb0_released", 32'(debounced[0]), 32'h0);

        // Glitch rejection, then a real press
        level[1] = 1'b1;
        wait_cycles(10);
        level[1] = 1'b0;
        wait_cycles(30);
        check("deb1_glitch", 32'(debounced[1]), 32'h0);
        c = cyc;
        level[1] = 1'b1;
        expect_tick(c + LAT, 4'b0010);
        wait_cycles(20);
        level[1] = 1'b0;
        wait_cycles(30);

        // Both edges
        mode = 2'b10;
        c = cyc;
        level[2] = 1'b1;
        expect_tick(c + LAT, 4'b0100);
        wait_cycles(30);
        level[2] = 1'b0;
        expect_tick(c + 30 + LAT, 4'b0100);
        wait_cycles(40);

        // Auto-repeat: T, T+64, then every 16 cycles until debounced falls
        mode = 2'b11;
        c = cyc;
        level[3] = 1'b1;
        expect_tick(c + LAT, 4'b1000);
        fall_at = c + 200 + LAT;
        for (int unsigned t = c + LAT + 64; t < fall_at; t += 16) expect_tick(t, 4'b1000);
        wait_cycles(200);
        level[3] = 1'b0;
        wait_cycles(40);
        check("deb3_released", 32'(debounced[3]), 32'h0);

        // en low across the press, raised while held: no tick at all
        mode = 2'b00;
        en   = 1'b0;
        level[0] = 1'b1;
        wait_cycles(25);
        check("deb0_en_low", 32'(debounced[0]), 32'h1);
        en = 1'b1;
        wait_cycles(20);
        level[0] = 1'b0;
        wait_cycles(30);

        // Two channels pressed together tick together
        c = cyc;
        level[1:0] = 2'b11;
        expect_tick(c + LAT, 4'b0011);
        wait_cycles(25);
        check("deb_pair", 32'(debounced), 32'h3);
        level[1:0] = 2'b00;
        wait_cycles(30);

        // Reset while HELD in repeat mode, key still down
        mode = 2'b11;
        c = cyc;
        level[3] = 1'b1;
        expect_tick(c + LAT, 4'b1000);
        wait_cycles(30);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_async_tick", 32'(tick), 32'h0);
        check("rst_async_debounced", 32'(debounced), 32'h0);
        wait_cycles(3);
        c = cyc;
        rst = 1'b1;
        expect_tick(c + LAT, 4'b1000);
        wait_cycles(40);
        level[3] = 1'b0;
        wait_cycles(40);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
